// File: rtl/ped_signal.sv
// Pedestrian crossing controller: grants WALK then flashing DON'T-WALK inside a
// vehicle red phase when a button request is pending; aborts to STOP if red ends early.
module ped_signal #(
  parameter int WALK_TIME  = 8,
  parameter int FLASH_TIME = 4,
  parameter int BLINK_DIV  = 2
) (
  input  logic       ck,
  input  logic       rs,
  input  logic [2:0] light,
  input  logic       btn,
  output logic       req_pend,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] ped_cnt,
  output logic [1:0] pstate,
  output logic       fault
);

  // No handshake: light and btn are synchronous levels sampled every edge, and every
  // output is a register that updates on that same edge (no valid/ready qualifiers).

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_WALK  = 2'b01,
    ST_FLASH = 2'b10,
    ST_BAD   = 2'b11
  } pstate_e;

  localparam int             DW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST   = DW'(BLINK_DIV - 1);
  localparam logic [3:0]     WALK_LOAD  = 4'(WALK_TIME - 1);
  localparam logic [3:0]     FLASH_LOAD = 4'(FLASH_TIME - 1);

  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b100;

  pstate_e       state_q, state_n;
  logic          btn_d;
  logic [2:0]    light_d;
  logic          blink_q, blink_n;
  logic [DW-1:0] div_q, div_n;

  logic          walk_n, dont_n, rp_n, fault_n;
  logic [3:0]    cnt_n;
  logic          enter_walk;

  logic          is_red, light_valid, btn_rise, red_rise;

  assign pstate      = state_q;
  assign is_red      = (light == L_RED);
  assign light_valid = (light == L_GREEN) || (light == L_YELLOW) || (light == L_RED);
  assign btn_rise    = btn & ~btn_d;
  assign red_rise    = is_red & (light_d != L_RED);

  always_comb begin
    state_n    = state_q;
    walk_n     = 1'b0;
    dont_n     = 1'b1;
    cnt_n      = 4'd0;
    blink_n    = blink_q;
    div_n      = div_q;
    enter_walk = 1'b0;

    case (state_q)
      ST_STOP: begin
        // Entry only on the first red edge; a request raised mid-red waits for the next red.
        if (red_rise && (req_pend || btn_rise)) begin
          state_n    = ST_WALK;
          walk_n     = 1'b1;
          dont_n     = 1'b0;
          cnt_n      = WALK_LOAD;
          enter_walk = 1'b1;
        end
      end

      ST_WALK: begin
        if (!is_red) begin
          state_n = ST_STOP;
        end else if (ped_cnt == 4'd0) begin
          state_n = ST_FLASH;
          cnt_n   = FLASH_LOAD;
          blink_n = 1'b1;
          div_n   = '0;
          dont_n  = 1'b1;
        end else begin
          walk_n = 1'b1;
          dont_n = 1'b0;
          cnt_n  = ped_cnt - 4'd1;
        end
      end

      ST_FLASH: begin
        if (!is_red || (ped_cnt == 4'd0)) begin
          state_n = ST_STOP;
        end else begin
          cnt_n = ped_cnt - 4'd1;
          if (div_q == DIV_LAST) begin
            div_n   = '0;
            blink_n = ~blink_q;
          end else begin
            div_n = div_q + 1'b1;
          end
          dont_n = blink_n;
        end
      end

      default: begin
        state_n = ST_STOP;
      end
    endcase

    // Entering WALK consumes the request, even against a simultaneous button edge.
    if (enter_walk) begin
      rp_n = 1'b0;
    end else if (btn_rise) begin
      rp_n = 1'b1;
    end else begin
      rp_n = req_pend;
    end

    fault_n = ~light_valid;
  end

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      state_q   <= ST_STOP;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      req_pend  <= 1'b0;
      ped_cnt   <= 4'd0;
      fault     <= 1'b0;
      btn_d     <= 1'b0;
      light_d   <= 3'b000;
      blink_q   <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_n;
      walk      <= walk_n;
      dont_walk <= dont_n;
      req_pend  <= rp_n;
      ped_cnt   <= cnt_n;
      fault     <= fault_n;
      btn_d     <= btn;
      light_d   <= light;
      blink_q   <= blink_n;
      div_q     <= div_n;
    end
  end

endmodule

// File: tb/tb_ped_signal.sv
// Bench for ped_signal: scripted light/button sequences with expected output
// vectors queued per edge and compared against the sampled DUT outputs.
module tb_ped_signal;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       ck;
  logic       rs;
  logic [2:0] light;
  logic       btn;
  logic       req_pend;
  logic       walk;
  logic       dont_walk;
  logic [3:0] ped_cnt;
  logic [1:0] pstate;
  logic       fault;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int         n_tests;
  int         n_fail;

  ped_signal #(
    .WALK_TIME (8),
    .FLASH_TIME(4),
    .BLINK_DIV (2)
  ) dut (
    .ck       (ck),
    .rs       (rs),
    .light    (light),
    .btn      (btn),
    .req_pend (req_pend),
    .walk     (walk),
    .dont_walk(dont_walk),
    .ped_cnt  (ped_cnt),
    .pstate   (pstate),
    .fault    (fault)
  );

  // clock / reset
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Vector layout: {pstate, walk, dont_walk, req_pend, ped_cnt, fault}
  function automatic logic [9:0] ex(input logic [1:0] ps, input logic w, input logic dw,
                                    input logic rp, input logic [3:0] c, input logic f);
    return {ps, w, dw, rp, c, f};
  endfunction

  function automatic logic [9:0] stop_e(input logic rp, input logic f);
    return ex(2'b00, 1'b0, 1'b1, rp, 4'd0, f);
  endfunction

  function automatic logic [9:0] walk_e(input logic rp, input logic [3:0] c);
    return ex(2'b01, 1'b1, 1'b0, rp, c, 1'b0);
  endfunction

  function automatic logic [9:0] flash_e(input logic rp, input logic dw, input logic [3:0] c);
    return ex(2'b10, 1'b0, dw, rp, c, 1'b0);
  endfunction

  // driver tasks
  task automatic sample();
    obs_q.push_back({pstate, walk, dont_walk, req_pend, ped_cnt, fault});
  endtask

  task automatic drive(input logic [2:0] l, input logic b, input logic [9:0] e);
    @(negedge ck);
    light = l;
    btn   = b;
    exp_q.push_back(e);
    @(posedge ck);
    #1;
    sample();
  endtask

  task automatic test_reset();
    logic [9:0] e, o;
    int step = 0;
    rs    = 1'b0;
    light = G;
    btn   = 1'b0;
    repeat (2) @(negedge ck);
    #1;
    exp_q.push_back(stop_e(1'b0, 1'b0));
    sample();
    rs = 1'b1;
    repeat (20) drive(G, 1'b0, stop_e(1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      step++;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got %b expected %b", step, o, e);
      end
    end
  endtask

  task automatic test_walk_cycle();
    logic [9:0] e, o;
    int step = 0;
    int gap  = $urandom_range(0, 2);
    drive(G, 1'b1, stop_e(1'b1, 1'b0));
    drive(G, 1'b0, stop_e(1'b1, 1'b0));
    repeat (gap) drive(G, 1'b0, stop_e(1'b1, 1'b0));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    drive(R, 1'b0, walk_e(1'b0, 4'd7));
    for (int c = 6; c >= 0; c--) drive(R, 1'b0, walk_e(1'b0, 4'(c)));
    drive(R, 1'b0, flash_e(1'b0, 1'b1, 4'd3));
    drive(R, 1'b0, flash_e(1'b0, 1'b1, 4'd2));
    drive(R, 1'b0, flash_e(1'b0, 1'b0, 4'd1));
    drive(R, 1'b0, flash_e(1'b0, 1'b0, 4'd0));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      step++;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL walk_cycle step %0d: got %b expected %b", step, o, e);
      end
    end
  endtask

  task automatic test_late_request();
    logic [9:0] e, o;
    int step = 0;
    drive(Y, 1'b0, stop_e(1'b0, 1'b0));
    drive(R, 1'b0, stop_e(1'b0, 1'b0));
    drive(R, 1'b0, stop_e(1'b0, 1'b0));
    drive(R, 1'b0, stop_e(1'b0, 1'b0));
    drive(R, 1'b1, stop_e(1'b1, 1'b0));
    repeat (3) drive(R, 1'b0, stop_e(1'b1, 1'b0));
    drive(G, 1'b0, stop_e(1'b1, 1'b0));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    drive(R, 1'b0, walk_e(1'b0, 4'd7));
    drive(R, 1'b0, walk_e(1'b0, 4'd6));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      step++;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL late_request step %0d: got %b expected %b", step, o, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [9:0] e, o;
    int step = 0;
    drive(G, 1'b1, stop_e(1'b1, 1'b0));
    drive(G, 1'b0, stop_e(1'b1, 1'b0));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    drive(R, 1'b0, walk_e(1'b0, 4'd7));
    drive(R, 1'b0, walk_e(1'b0, 4'd6));
    drive(R, 1'b0, walk_e(1'b0, 4'd5));
    drive(R, 1'b0, walk_e(1'b0, 4'd4));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      step++;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort step %0d: got %b expected %b", step, o, e);
      end
    end
  endtask

  task automatic test_fault();
    logic [9:0] e, o;
    int step = 0;
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    drive(3'b110, 1'b0, stop_e(1'b0, 1'b1));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    drive(3'b000, 1'b0, stop_e(1'b0, 1'b1));
    drive(G, 1'b1, stop_e(1'b1, 1'b0));
    drive(G, 1'b0, stop_e(1'b1, 1'b0));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    drive(R, 1'b0, walk_e(1'b0, 4'd7));
    drive(R, 1'b0, walk_e(1'b0, 4'd6));
    drive(3'b011, 1'b0, stop_e(1'b0, 1'b1));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    // An invalid code is not red, so the following red is a fresh red_rise.
    drive(G, 1'b1, stop_e(1'b1, 1'b0));
    drive(3'b111, 1'b0, stop_e(1'b1, 1'b1));
    drive(R, 1'b0, walk_e(1'b0, 4'd7));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      step++;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fault step %0d: got %b expected %b", step, o, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] e, o;
    int step = 0;
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    drive(Y, 1'b0, stop_e(1'b0, 1'b0));
    drive(R, 1'b1, walk_e(1'b0, 4'd7));
    drive(R, 1'b1, walk_e(1'b0, 4'd6));
    drive(R, 1'b0, walk_e(1'b0, 4'd5));
    drive(Y, 1'b0, stop_e(1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      step++;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL simultaneous step %0d: got %b expected %b", step, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e, o;
    int step = 0;
    int gap  = $urandom_range(1, 3);
    drive(G, 1'b1, stop_e(1'b1, 1'b0));
    drive(G, 1'b0, stop_e(1'b1, 1'b0));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    drive(R, 1'b0, walk_e(1'b0, 4'd7));
    for (int c = 6; c >= 0; c--) drive(R, 1'b0, walk_e(1'b0, 4'(c)));
    drive(R, 1'b1, flash_e(1'b1, 1'b1, 4'd3));
    drive(R, 1'b0, flash_e(1'b1, 1'b1, 4'd2));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    repeat (gap) drive(G, 1'b0, stop_e(1'b1, 1'b0));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    drive(R, 1'b0, walk_e(1'b0, 4'd7));
    drive(R, 1'b0, walk_e(1'b0, 4'd6));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      step++;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %b expected %b", step, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_flash();
    logic [9:0] e, o;
    int step = 0;
    drive(G, 1'b1, stop_e(1'b1, 1'b0));
    drive(G, 1'b0, stop_e(1'b1, 1'b0));
    drive(Y, 1'b0, stop_e(1'b1, 1'b0));
    drive(R, 1'b0, walk_e(1'b0, 4'd7));
    drive(R, 1'b1, walk_e(1'b1, 4'd6));
    for (int c = 5; c >= 0; c--) drive(R, 1'b0, walk_e(1'b1, 4'(c)));
    drive(R, 1'b0, flash_e(1'b1, 1'b1, 4'd3));
    drive(R, 1'b0, flash_e(1'b1, 1'b1, 4'd2));
    #2;
    rs = 1'b0;
    #1;
    exp_q.push_back(stop_e(1'b0, 1'b0));
    sample();
    @(negedge ck);
    rs    = 1'b1;
    light = G;
    btn   = 1'b0;
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    drive(R, 1'b0, stop_e(1'b0, 1'b0));
    drive(G, 1'b0, stop_e(1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      step++;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_flash step %0d: got %b expected %b", step, o, e);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rs      = 1'b0;
    light   = G;
    btn     = 1'b0;
    test_reset();
    test_walk_cycle();
    test_late_request();
    test_abort();
    test_fault();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_flash();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
